ctrl_pipe: RTL and testbench

- Pipelined successor to the single-cycle opcode controller.
- Decodes the ID-stage opcode into a packed control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers with valid bits.
- Also detects load-use hazards, generates EX forwarding selects, handles stall and flush (including flush pending across a stall), and keeps stall/flush event counters.
- Sits between the instruction decode stage and the datapath pipeline registers.

---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/ctrl_decode.sv | 80 ++++++++
 rtl/ctrl_pipe.sv | 152 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, encoding and control-bundle definitions
// for the pipelined instruction controller.
package ctrl_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_FN   = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_LOAD  = 2'b01;
  localparam logic [1:0] M2R_PC4   = 2'b10;
  localparam logic [1:0] M2R_AUIPC = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle,
// illegal-opcode flag and rs2-usage flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic       i_valid,
  output ctrl_t      o_ctrl,
  output logic       o_illegal,
  output logic       o_uses_rs2
);

  logic w_known;

  // One-hot opcode match into the control bundle
  always_comb begin
    o_ctrl     = '0;
    o_uses_rs2 = 1'b0;
    w_known    = 1'b1;
    unique case (1'b1)
      (i_opcode == R_TYPE): begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FN;
        o_uses_rs2       = 1'b1;
      end
      (i_opcode == OP_IMM): begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FN;
      end
      (i_opcode == LW): begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_to_reg = M2R_LOAD;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.alu_op     = ALU_ADD;
      end
      (i_opcode == SW): begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_op    = ALU_ADD;
        o_uses_rs2       = 1'b1;
      end
      (i_opcode == BR): begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALU_BR;
        o_uses_rs2    = 1'b1;
      end
      (i_opcode == JAL): begin
        o_ctrl.mem_to_reg = M2R_PC4;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jal        = 1'b1;
        o_ctrl.alu_op     = ALU_PASS;
      end
      (i_opcode == JALR): begin
        o_ctrl.mem_to_reg = M2R_PC4;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jalr       = 1'b1;
        o_ctrl.alu_op     = ALU_ADD;
      end
      (i_opcode == LUI): begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.lui       = 1'b1;
        o_ctrl.alu_op    = ALU_PASS;
      end
      (i_opcode == AUIPC): begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_to_reg = M2R_AUIPC;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.auipc      = 1'b1;
        o_ctrl.alu_op     = ALU_PASS;
      end
      default: w_known = 1'b0;
    endcase
  end

  assign o_illegal = i_valid & ~w_known;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined controller: ID decode carried through EX/MEM/WB,
// load-use hazard, EX forwarding, stall/flush and event counters.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              stall_in,
  input  logic              flush_in,
  output ctrl_t             ex_ctrl,
  output ctrl_t             mem_ctrl,
  output ctrl_t             wb_ctrl,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              hazard_stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t             w_id_ctrl;
  logic              w_uses_rs2;
  logic              w_hazard;
  logic              w_flush;
  logic              w_bubble;

  ctrl_t             r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
  logic              r_ex_valid, r_mem_valid, r_wb_valid;
  logic [REG_AW-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
  logic [REG_AW-1:0] r_mem_rd, r_wb_rd;
  logic              r_flush_pending;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  ctrl_decode u_dec (
    .i_opcode   (id_opcode),
    .i_valid    (id_valid),
    .o_ctrl     (w_id_ctrl),
    .o_illegal  (illegal_op),
    .o_uses_rs2 (w_uses_rs2)
  );

  assign w_hazard = r_ex_valid & r_ex_ctrl.mem_read
                  & (r_ex_rd != '0) & id_valid
                  & ((r_ex_rd == id_rs1)
                   | (w_uses_rs2 & (r_ex_rd == id_rs2)));

  assign w_flush  = flush_in | r_flush_pending;
  assign w_bubble = w_flush | w_hazard | ~id_valid;

  // Stage registers: hold on stall, bubble ID/EX on flush/hazard
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ex_ctrl       <= '0;
      r_mem_ctrl      <= '0;
      r_wb_ctrl       <= '0;
      r_ex_valid      <= 1'b0;
      r_mem_valid     <= 1'b0;
      r_wb_valid      <= 1'b0;
      r_ex_rd         <= '0;
      r_ex_rs1        <= '0;
      r_ex_rs2        <= '0;
      r_mem_rd        <= '0;
      r_wb_rd         <= '0;
      r_flush_pending <= 1'b0;
    end else if (stall_in) begin
      if (flush_in) r_flush_pending <= 1'b1;
    end else begin
      r_wb_ctrl   <= r_mem_ctrl;
      r_wb_valid  <= r_mem_valid;
      r_wb_rd     <= r_mem_rd;
      r_mem_ctrl  <= r_ex_ctrl;
      r_mem_valid <= r_ex_valid;
      r_mem_rd    <= r_ex_rd;
      if (w_bubble) begin
        r_ex_ctrl  <= '0;
        r_ex_valid <= 1'b0;
        r_ex_rd    <= '0;
        r_ex_rs1   <= '0;
        r_ex_rs2   <= '0;
      end else begin
        r_ex_ctrl  <= w_id_ctrl;
        r_ex_valid <= 1'b1;
        r_ex_rd    <= id_rd;
        r_ex_rs1   <= id_rs1;
        r_ex_rs2   <= id_rs2;
      end
      r_flush_pending <= 1'b0;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_in && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (!stall_in && w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  generate
    if (FWD_EN) begin : g_fwd
      logic w_a_mem, w_a_wb, w_b_mem, w_b_wb;
      logic w_mem_wr, w_wb_wr;

      assign w_mem_wr = r_mem_valid & r_mem_ctrl.reg_write
                      & (r_mem_rd != '0);
      assign w_wb_wr  = r_wb_valid & r_wb_ctrl.reg_write
                      & (r_wb_rd != '0);
      assign w_a_mem  = w_mem_wr & (r_mem_rd == r_ex_rs1);
      assign w_a_wb   = w_wb_wr & (r_wb_rd == r_ex_rs1);
      assign w_b_mem  = w_mem_wr & (r_mem_rd == r_ex_rs2);
      assign w_b_wb   = w_wb_wr & (r_wb_rd == r_ex_rs2);

      assign fwd_a = w_a_mem ? FWD_MEM
                   : w_a_wb  ? FWD_WB : FWD_RF;
      assign fwd_b = w_b_mem ? FWD_MEM
                   : w_b_wb  ? FWD_WB : FWD_RF;
    end else begin : g_nofwd
      assign fwd_a = FWD_RF;
      assign fwd_b = FWD_RF;
    end
  endgenerate

  assign ex_ctrl      = r_ex_ctrl;
  assign mem_ctrl     = r_mem_ctrl;
  assign wb_ctrl      = r_wb_ctrl;
  assign ex_valid     = r_ex_valid;
  assign mem_valid    = r_mem_valid;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign hazard_stall = w_hazard;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed cases plus random traffic
// against a slot-array reference model.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, id_valid, stall_in, flush_in;
  logic [6:0] id_opcode;
  logic [4:0] id_rd, id_rs1, id_rs2;

  ctrl_t       ex_ctrl, mem_ctrl, wb_ctrl;
  logic        ex_valid, mem_valid, wb_valid;
  logic [4:0]  wb_rd;
  logic        hazard_stall, illegal_op;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  ctrl_t      s_exc, s_memc, s_wbc;
  logic       s_exv, s_memv, s_wbv, s_hz, s_il;
  logic [4:0] s_wbrd;
  logic [1:0] s_fa, s_fb;
  logic [3:0] s_scnt, s_fcnt;

  always #5 clk = ~clk;

  ctrl_pipe u_dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .stall_in(stall_in), .flush_in(flush_in),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .hazard_stall(hazard_stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .illegal_op(illegal_op), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  ctrl_pipe #(.CNT_W(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .stall_in(stall_in), .flush_in(flush_in),
    .ex_ctrl(s_exc), .mem_ctrl(s_memc), .wb_ctrl(s_wbc),
    .ex_valid(s_exv), .mem_valid(s_memv), .wb_valid(s_wbv),
    .wb_rd(s_wbrd), .hazard_stall(s_hz), .fwd_a(s_fa),
    .fwd_b(s_fb), .illegal_op(s_il), .stall_cnt(s_scnt),
    .flush_cnt(s_fcnt)
  );

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_IMM = 7'b0010011;
  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_JR  = 7'b1100111;
  localparam logic [6:0] T_LUI = 7'b0110111;
  localparam logic [6:0] T_AUI = 7'b0010111;
  localparam logic [6:0] T_BAD = 7'b1111111;

  typedef struct {
    bit         v;
    ctrl_t      c;
    logic [4:0] rd, rs1, rs2;
  } slot_t;

  typedef struct {
    ctrl_t      exc, memc, wbc;
    bit         exv, memv, wbv, hz, il;
    logic [4:0] wbrd;
    logic [1:0] fa, fb;
    int         scnt, fcnt;
  } exp_t;

  exp_t  sb[$];
  slot_t m_ex, m_mem, m_wb;
  bit    m_fp;
  int    m_scnt, m_fcnt;
  bit    last_hz;
  int    n_tests = 0;
  int    n_fail  = 0;
  logic [6:0] ops[10];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic slot_t zslot();
    slot_t z;
    z.v = 1'b0; z.c = '0;
    z.rd = '0; z.rs1 = '0; z.rs2 = '0;
    return z;
  endfunction

  // Reference decode table, one row per opcode class
  function automatic ctrl_t ref_dec(input logic [6:0] op,
                                    output bit urs2,
                                    output bit known);
    ctrl_t c;
    c = '0; urs2 = 1'b0; known = 1'b1;
    case (op)
      T_R:   begin c.reg_write = 1; c.alu_op = 2'b10; urs2 = 1; end
      T_IMM: begin c.alu_src = 1; c.reg_write = 1;
                   c.alu_op = 2'b10; end
      T_LW:  begin c.alu_src = 1; c.mem_to_reg = 2'b01;
                   c.reg_write = 1; c.mem_read = 1; end
      T_SW:  begin c.alu_src = 1; c.mem_write = 1; urs2 = 1; end
      T_BR:  begin c.branch = 1; c.alu_op = 2'b01; urs2 = 1; end
      T_JAL: begin c.mem_to_reg = 2'b10; c.reg_write = 1;
                   c.jal = 1; c.alu_op = 2'b11; end
      T_JR:  begin c.mem_to_reg = 2'b10; c.reg_write = 1;
                   c.jalr = 1; end
      T_LUI: begin c.alu_src = 1; c.reg_write = 1; c.lui = 1;
                   c.alu_op = 2'b11; end
      T_AUI: begin c.alu_src = 1; c.mem_to_reg = 2'b11;
                   c.reg_write = 1; c.auipc = 1;
                   c.alu_op = 2'b11; end
      default: known = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] ref_fwd(logic [4:0] rs);
    if (m_mem.v && m_mem.c.reg_write && m_mem.rd != 0
        && m_mem.rd == rs) return 2'b10;
    if (m_wb.v && m_wb.c.reg_write && m_wb.rd != 0
        && m_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Drive one cycle, queue the expected view, advance the model
  task automatic step(bit v, logic [6:0] op, logic [4:0] rd,
                      logic [4:0] rs1, logic [4:0] rs2,
                      bit st = 0, bit fl = 0, bit rst = 0,
                      int ehz = -1, int eil = -1);
    exp_t  e;
    ctrl_t dc;
    bit    u, k, hz, fe;
    reset_n = !rst; id_valid = v; id_opcode = op;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    stall_in = st; flush_in = fl;
    dc = ref_dec(op, u, k);
    hz = m_ex.v && m_ex.c.mem_read && m_ex.rd != 0 && v
         && (m_ex.rd == rs1 || (u && m_ex.rd == rs2));
    last_hz = hz;
    e.exc = m_ex.c;  e.memc = m_mem.c; e.wbc = m_wb.c;
    e.exv = m_ex.v;  e.memv = m_mem.v; e.wbv = m_wb.v;
    e.wbrd = m_wb.rd;
    e.hz = hz; e.il = v && !k;
    e.fa = ref_fwd(m_ex.rs1); e.fb = ref_fwd(m_ex.rs2);
    e.scnt = m_scnt; e.fcnt = m_fcnt;
    sb.push_back(e);
    if (ehz >= 0) begin
      #1 chk("hazard_now", hazard_stall, ehz);
    end
    if (eil >= 0) begin
      #1 chk("illegal_now", illegal_op, eil);
    end
    @(posedge clk);
    if (rst) begin
      m_ex = zslot(); m_mem = zslot(); m_wb = zslot();
      m_fp = 0; m_scnt = 0; m_fcnt = 0;
    end else if (st) begin
      m_fp = m_fp | fl;
      m_scnt++;
    end else begin
      fe = fl || m_fp;
      m_wb = m_mem; m_mem = m_ex;
      if (fe || hz || !v) m_ex = zslot();
      else begin
        m_ex.v = 1; m_ex.c = dc;
        m_ex.rd = rd; m_ex.rs1 = rs1; m_ex.rs2 = rs2;
      end
      m_fp = 0;
      if (fe) m_fcnt++;
    end
    #1;
  endtask

  task automatic nop();
    step(0, 7'd0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs with the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_ctrl", ex_ctrl, e.exc);
      chk("mem_ctrl", mem_ctrl, e.memc);
      chk("wb_ctrl", wb_ctrl, e.wbc);
      chk("ex_valid", ex_valid, e.exv);
      chk("mem_valid", mem_valid, e.memv);
      chk("wb_valid", wb_valid, e.wbv);
      if (e.wbv) chk("wb_rd", wb_rd, e.wbrd);
      chk("hazard_stall", hazard_stall, e.hz);
      chk("illegal_op", illegal_op, e.il);
      if (e.exv) begin
        chk("fwd_a", fwd_a, e.fa);
        chk("fwd_b", fwd_b, e.fb);
      end
      chk("stall_cnt", stall_cnt, (e.scnt > 65535) ? 65535 : e.scnt);
      chk("flush_cnt", flush_cnt, (e.fcnt > 65535) ? 65535 : e.fcnt);
      chk("sat_stall_cnt", s_scnt, (e.scnt > 15) ? 15 : e.scnt);
      chk("sat_flush_cnt", s_fcnt, (e.fcnt > 15) ? 15 : e.fcnt);
    end
  end

  initial begin
    int guard;
    logic [6:0] op;
    logic [4:0] rd, r1, r2;
    bit v, st, fl, rs;
    ops = '{T_R, T_IMM, T_LW, T_SW, T_BR,
            T_JAL, T_JR, T_LUI, T_AUI, T_BAD};
    m_ex = zslot(); m_mem = zslot(); m_wb = zslot();
    m_fp = 0; m_scnt = 0; m_fcnt = 0; last_hz = 0;

    reset_n = 0; id_valid = 1; id_opcode = T_R;
    id_rd = 1; id_rs1 = 2; id_rs2 = 3;
    stall_in = 0; flush_in = 0;
    @(posedge clk); #1;
    step(1, T_R, 1, 2, 3, .rst(1));
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_wb_ctrl", wb_ctrl, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_stall_cnt", stall_cnt, 0);

    step(1, T_R, 7, 1, 2);
    chk("lat_wb_v1", wb_valid, 0);
    nop();
    chk("lat_wb_v2", wb_valid, 0);
    nop();
    chk("lat_wb_v3", wb_valid, 1);
    chk("lat_wb_rw", wb_ctrl.reg_write, 1);
    chk("lat_wb_aluop", wb_ctrl.alu_op, 2'b10);
    chk("lat_wb_rd", wb_rd, 7);

    step(1, T_LW, 5, 1, 0);
    step(1, T_R, 6, 5, 2, .ehz(1));
    chk("lu_bubble", ex_valid, 0);
    step(1, T_R, 6, 5, 2, .ehz(0));
    step(1, T_LW, 5, 1, 0);
    step(1, T_SW, 0, 6, 5, .ehz(1));
    step(1, T_SW, 0, 6, 5, .ehz(0));
    step(1, T_LW, 0, 1, 0);
    step(1, T_R, 8, 0, 0, .ehz(0));
    repeat (3) nop();

    step(1, T_R, 3, 1, 2);
    step(1, T_R, 3, 1, 2);
    step(1, T_R, 9, 3, 3);
    chk("fwd_mem_a", fwd_a, 2'b10);
    chk("fwd_mem_b", fwd_b, 2'b10);
    step(1, T_R, 4, 1, 2);
    step(1, T_R, 10, 1, 2);
    step(1, T_R, 11, 4, 0);
    chk("fwd_wb_a", fwd_a, 2'b01);
    chk("fwd_wb_b", fwd_b, 2'b00);

    step(1, T_R, 12, 1, 2);
    step(1, T_R, 13, 1, 2, .st(1));
    step(1, T_R, 13, 1, 2, .st(1), .fl(1));
    step(1, T_R, 13, 1, 2, .st(1));
    chk("stl_flush_cnt", flush_cnt, 0);
    chk("stl_stall_cnt", stall_cnt, 3);
    chk("stl_frozen", ex_valid, 1);
    step(1, T_R, 13, 1, 2);
    chk("fp_bubble", ex_valid, 0);
    chk("fp_flush_cnt", flush_cnt, 1);
    chk("fp_stall_cnt", stall_cnt, 3);
    chk("fp_mem_valid", mem_valid, 1);

    for (int i = 0; i < 10; i++) begin
      step(1, ops[i], 1, 2, 3, .eil(ops[i] == T_BAD ? 1 : 0));
      if (ops[i] == T_JAL) begin
        chk("jal_mem_write", ex_ctrl.mem_write, 0);
        chk("jal_m2r", ex_ctrl.mem_to_reg, 2'b10);
      end
      if (ops[i] == T_BAD) chk("bad_bundle", ex_ctrl, 0);
    end

    repeat (20) step(0, 7'd0, 0, 0, 0, .st(1));
    chk("sat_hold1", s_scnt, 4'hF);
    repeat (2) step(0, 7'd0, 0, 0, 0, .st(1));
    chk("sat_hold2", s_scnt, 4'hF);

    for (int i = 0; i < 600; i++) begin
      if (!last_hz) begin
        v  = ($urandom_range(0, 9) < 8);
        op = ($urandom_range(0, 19) == 0) ?
             7'($urandom) : ops[$urandom_range(0, 8)];
        rd = 5'($urandom_range(0, 3));
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
      end
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(v, op, rd, r1, r2, st, fl, rs);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d queued expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
